// File: rtl/mealy_stream_ctrl_pkg.sv
// Shared types and the 5-state Mealy bit-detector transition table for the stream controller.
package mealy_stream_ctrl_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } core_state_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StHold  = 2'd2
    } ctrl_state_e;

    // Codes 5-7 fall into the defaults, so an upset recovers to S0.
    function automatic logic [2:0] mealy5_next(input logic [2:0] s, input logic x);
        logic [2:0] n;
        case (s)
            S0:      n = x ? S4 : S3;
            S1:      n = x ? S4 : S1;
            S2:      n = x ? S0 : S2;
            S3:      n = x ? S2 : S1;
            S4:      n = x ? S3 : S2;
            default: n = S0;
        endcase
        return n;
    endfunction

    function automatic logic mealy5_y(input logic [2:0] s, input logic x);
        logic y;
        case (s)
            S0, S1, S2, S3: y = x;
            default:        y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/mealy_stream_ctrl_core.sv
// mealy5_core: registered 5-state Mealy bit detector with a synchronous load-to-S0.
module mealy5_core
    import mealy_stream_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step_i,
    input  logic       load_s0_i,
    input  logic       x_i,
    output logic       y_o,
    output logic [2:0] state_o
);

    logic [2:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        y_o     = mealy5_y(state_q, x_i);
        if (load_s0_i) begin
            state_d = S0;
        end else if (step_i) begin
            state_d = mealy5_next(state_q, x_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/mealy_stream_ctrl.sv
// Serialises words LSB-first through mealy5_core and returns the per-bit outputs over valid/ready.
module mealy_stream_ctrl
    import mealy_stream_ctrl_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    input  logic         in_restart_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [2:0]   out_state_o,
    output logic         busy_o
);

    localparam int unsigned CntW = $clog2(W);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    ctrl_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_q, data_d;
    logic [W-1:0]  result_q, result_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [2:0]    out_state_q, out_state_d;

    logic          accept;
    logic          core_x;
    logic          core_y;
    logic [2:0]    core_state;

    assign accept = (state_q == StIdle) && in_valid_i;
    assign core_x = data_q[cnt_q];

    mealy5_core u_core (
        .clk       (clk),
        .rst       (rst),
        .step_i    (state_q == StShift),
        .load_s0_i (accept && in_restart_i),
        .x_i       (core_x),
        .y_o       (core_y),
        .state_o   (core_state)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        result_d    = result_q;
        out_data_d  = out_data_q;
        out_state_d = out_state_q;
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    data_d   = in_data_i;
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                result_d[cnt_q] = core_y;
                cnt_d           = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    cnt_d       = '0;
                    state_d     = StHold;
                    // Publish on the same edge so the result is stable for the whole HOLD.
                    out_data_d  = result_d;
                    out_state_d = mealy5_next(core_state, core_x);
                end
            end
            StHold: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            data_q      <= '0;
            result_q    <= '0;
            out_data_q  <= '0;
            out_state_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            result_q    <= result_d;
            out_data_q  <= out_data_d;
            out_state_q <= out_state_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StHold);
    assign busy_o      = (state_q == StShift) || (state_q == StHold);
    assign out_data_o  = out_data_q;
    assign out_state_o = out_state_q;

endmodule

// File: doc/mealy_stream_ctrl.md
Name: mealy_stream_ctrl

Overview:
- Sequencer that serialises parallel words through the team's 5-state Mealy bit-detector core, one bit per clock, LSB first.
- Collects the per-bit Mealy output into a result word and returns it, together with the core's final state, over a valid/ready interface.
- Core state persists across words unless the requester asks for a restart, so a long bit stream can be fed as consecutive words.

Parameters:
W, 8, word width in bits (≥2); bit counter width is clog2(W).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  request word present
in_ready  output  1  controller accepts a word (IDLE only)
in_data  input  W  bits to feed the core, bit 0 first
in_restart  input  1  sampled with the word: force core to S0 before the first bit
out_valid  output  1  result word present
out_ready  input  1  consumer accepts result
out_data  output  W  Mealy outputs; bit i is the output produced for in_data[i]
out_state  output  3  core state after the last bit of the word
busy  output  1  high in SHIFT or HOLD

Behaviour:
- Reset (rst=0, asynchronous):
  - Controller goes to IDLE; core state goes to S0 (3'b000).
  - bit counter=0, data/result registers=0.
  - out_valid=0, out_data=0, out_state=0, busy=0, in_ready=1 once reset is released.
  - Reset mid-SHIFT or mid-HOLD abandons the word silently; no partial result is ever presented.
- Core transition table (codes S0..S4 = 0..4), written as x → y/next:
  - S0: 1→1/S4, 0→0/S3
  - S1: 1→1/S4, 0→0/S1
  - S2: 1→1/S0, 0→0/S2
  - S3: 1→1/S2, 0→0/S1
  - S4: 1→0/S3, 0→0/S2
  - Codes 5–7: y=0, next=S0.
- The core advances only on SHIFT cycles; it holds its state in IDLE and HOLD.
- Controller FSM:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data, clear the counter, clear the result register, and go to SHIFT. If in_restart=1, load core state S0 on the same edge; otherwise keep the current core state.
  - SHIFT: in_ready=0. Each cycle, feed x=data[cnt] to the core, write y to result[cnt], advance the core state, and increment cnt. In the cycle with cnt==W-1, go to HOLD on the following edge and register out_state = the next state.
  - HOLD: out_valid=1. out_data and out_state stay stable until out_ready=1. On out_valid&out_ready, go to IDLE and drop out_valid on the next edge.
- Latency: handshake accepted at edge T; bits are processed in the W cycles after T; out_valid is high from edge T+W.
- Throughput: at most one word per W+2 cycles. in_ready is 0 throughout SHIFT and HOLD; in_valid is ignored there.
- out_ready may be held high in advance; the transfer then occurs in the first HOLD cycle.
- Backpressure in HOLD is unbounded and does not disturb the core state.
- out_data and out_state keep their last values after the transfer until the next word completes.
- in_restart is ignored except at the accept edge.
- The core may be fed illegal codes only by an upset; recovery to S0 follows from the table.

Decomposition:
- Shared package: state codes S0..S4, controller state encodings IDLE/SHIFT/HOLD (2-bit).
- One sub-module, mealy5_core:
  - Ports: clk, rst, step, load_s0, x; outputs y, state[2:0].
  - Registered state; combinational y from the table above.
  - load_s0 has priority over step.
- The controller holds the handshake FSM, counter, data and result registers.

Test Plan:
- W=8, restart=1, in_data=8'h01 → out_valid rises 8 cycles after accept; out_data=8'h01, out_state=S2 (3'd2).
- Next word without restart, in_data=8'h01 (core starts at S2) → out_data=8'h01, out_state=S1; then restart=1, in_data=8'hFF → out_data=8'hDD, out_state=S0.
- restart=1, in_data=8'h00 → out_data=8'h00, out_state=S1. With in_valid held high throughout, in_ready is 0 for exactly W+1 cycles (W in SHIFT, 1 in HOLD) before the next acceptance.
- Backpressure: out_ready=0 for 5 cycles in HOLD → out_valid, out_data and out_state stable, in_ready=0, busy=1. Raising out_ready gives one transfer and IDLE next cycle.
- Reset mid-SHIFT (rst low at cnt=3 for 2 ns, asynchronous) → out_valid=0, busy=0, core=S0 immediately. The next word 8'hFF with restart=0 still gives 8'hDD/S0.
- Back-to-back: out_ready tied 1, two words 8'h01 (restart) and 8'h01 (no restart) → results 8'h01/S2 then 8'h01/S1, with accept edges spaced exactly W+2 cycles.
